philv_pipe_chain: RTL and testbench

- Parametrised successor to the fixed IF/EX/MEM/WB register chain of the Philosophy-V core.
- DEPTH-stage elastic pipeline carrying a DATA_W payload plus a destination-register tag. Each stage has its own valid bit.
- Provides valid/ready handshakes, bubble collapsing, global flush, occupancy count, and a register-hazard scoreboard over all in-flight stages.
- Sits between decode and writeback; replaces the hard-wired stage registers.

---
 rtl/philv_pipe_chain.sv | 142 ++++++++++++++
 tb/tb_philv_pipe_chain.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/philv_pipe_chain.sv
// Elastic DEPTH-stage pipeline with per-stage valid bits, bubble collapsing, flush, occupancy and a rd hazard scoreboard.
// Define PHILV_PIPE_FWD_EN to add the fwd1/fwd2 operand-forwarding outputs.
module philv_pipe_chain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_rd_wr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_wr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  output logic              hazard,
`ifdef PHILV_PIPE_FWD_EN
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data,
`endif
  output logic [CNT_W-1:0]  occupancy
);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_rd_wr;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [CNT_W-1:0]  r_occ;

  logic [DEPTH-1:0]  w_move;
  logic              w_accept;
  logic              w_hazard;

  // Advance chain: an entry moves when its successor is empty or itself moving.
  always_comb begin
    logic carry;
    w_move            = '0;
    w_move[DEPTH-1]   = r_valid[DEPTH-1] & out_ready;
    carry             = w_move[DEPTH-1];
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      w_move[i] = r_valid[i] & (~r_valid[i+1] | carry);
      carry     = w_move[i];
    end
  end

  assign in_ready = ~r_valid[0] | w_move[0];
  assign w_accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_rd_wr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= '0;
        r_rd[i]   <= '0;
      end
    end else begin
      if (w_accept) begin
        r_data[0]  <= in_data;
        r_rd[0]    <= in_rd;
        r_rd_wr[0] <= in_rd_wr;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (w_move[i-1]) begin
          r_data[i]  <= r_data[i-1];
          r_rd[i]    <= r_rd[i-1];
          r_rd_wr[i] <= r_rd_wr[i-1];
        end
      end
      // Payload may still shift on flush; only the valid bits matter.
      if (flush) begin
        r_valid <= '0;
      end else begin
        r_valid[0] <= w_accept | (r_valid[0] & ~w_move[0]);
        for (int i = 1; i < int'(DEPTH); i++) begin
          r_valid[i] <= w_move[i-1] | (r_valid[i] & ~w_move[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + CNT_W'(w_accept) - CNT_W'(w_move[DEPTH-1]);
    end
  end

  // Pending write to a non-zero register matching either source.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_valid[i] && r_rd_wr[i] && (r_rd[i] != '0) &&
          ((r_rd[i] == chk_rs1) || (r_rd[i] == chk_rs2))) begin
        w_hazard = 1'b1;
      end
    end
  end

`ifdef PHILV_PIPE_FWD_EN
  // Scan oldest to youngest so the lowest-index match wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (r_valid[i] && r_rd_wr[i] && (r_rd[i] != '0)) begin
        if (r_rd[i] == chk_rs1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = r_data[i];
        end
        if (r_rd[i] == chk_rs2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = r_data[i];
        end
      end
    end
  end
`endif

  assign hazard    = w_hazard;
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign out_rd    = r_rd[DEPTH-1];
  assign out_rd_wr = r_rd_wr[DEPTH-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_philv_pipe_chain.sv
// Self-checking bench for philv_pipe_chain (DEPTH=4) with an in-order output scoreboard.
module tb_philv_pipe_chain;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 5;

  typedef struct packed {
    logic              rd_wr;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk, rst;
  logic              in_valid, in_ready, in_rd_wr;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_rd;
  logic              out_valid, out_ready, out_rd_wr;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_rd;
  logic              flush, hazard;
  logic [ADDR_W-1:0] chk_rs1, chk_rs2;
  logic [CNT_W-1:0]  occupancy;
`ifdef PHILV_PIPE_FWD_EN
  logic              fwd1_hit, fwd2_hit;
  logic [DATA_W-1:0] fwd1_data, fwd2_data;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  philv_pipe_chain dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .in_rd_wr  (in_rd_wr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_rd_wr (out_rd_wr),
    .flush     (flush),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .hazard    (hazard),
`ifdef PHILV_PIPE_FWD_EN
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
`endif
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: pop on output transfer, push on accept, clear on flush/reset.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got data=%h rd=%0d, required no output", out_data, out_rd);
        end else begin
          mon_e = sb_q.pop_front();
          if ({out_rd_wr, out_rd, out_data} !== mon_e) begin
            n_fail++;
            $display("FAIL sb_order: got wr=%b rd=%0d data=%h, required wr=%b rd=%0d data=%h",
                     out_rd_wr, out_rd, out_data, mon_e.rd_wr, mon_e.rd, mon_e.data);
          end
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back({in_rd_wr, in_rd, in_data});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] rd, input logic wr);
    in_valid = v;
    in_data  = d;
    in_rd    = rd;
    in_rd_wr = wr;
  endtask

  task automatic drain();
    int cyc = 0;
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid) && cyc < 20) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (sb_q.size() != 0 || out_valid !== 1'b0 || occupancy !== '0) begin
      n_fail++;
      $display("FAIL drain: got pending=%0d occ=%0d, required 0 0", sb_q.size(), occupancy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b0; flush = 1'b0; chk_rs1 = '0; chk_rs2 = '0;
    tick(); tick();
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== '0 || hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b occ=%0d hz=%b, required 0 0 0", out_valid, occupancy, hazard);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, DATA_W'(32'h10 + k), ADDR_W'(k + 1), 1'b1);
      tick();
      n_tests++;
      if (occupancy !== CNT_W'(k + 1)) begin
        n_fail++;
        $display("FAIL stream_occ%0d: got %0d, required %0d", k, occupancy, k + 1);
      end
      if (k == 2) begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_early: got out_valid=%b, required 0", out_valid);
        end
      end
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h10) begin
      n_fail++;
      $display("FAIL stream_latency: got v=%b d=%h, required 1 00000010", out_valid, out_data);
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    n_tests++;
    if (occupancy !== 5'd3) begin
      n_fail++;
      $display("FAIL stream_occ_after: got %0d, required 3", occupancy);
    end
    drain();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, DATA_W'(32'h20 + k), 5'd2, 1'b0);
      tick();
    end
    n_tests++;
    if (in_ready !== 1'b0 || occupancy !== 5'd4 || out_data !== 32'h20) begin
      n_fail++;
      $display("FAIL stall_full: got rdy=%b occ=%0d d=%h, required 0 4 00000020", in_ready, occupancy, out_data);
    end
    drive(1'b1, 32'h77, 5'd2, 1'b0);
    tick(); tick();
    n_tests++;
    if (out_data !== 32'h20 || occupancy !== 5'd4 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: got d=%h occ=%0d, required 00000020 4", out_data, occupancy);
    end
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (occupancy !== 5'd3 || in_ready !== 1'b1 || out_data !== 32'h21) begin
      n_fail++;
      $display("FAIL stall_release: got occ=%0d rdy=%b d=%h, required 3 1 00000021", occupancy, in_ready, out_data);
    end
    drain();
  endtask

  task automatic test_bubble_hazard();
    out_ready = 1'b0;
    drive(1'b1, 32'hA0, 5'd0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick(); tick();
    drive(1'b1, 32'hB0, 5'd5, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick(); tick();
    n_tests++;
    if (occupancy !== 5'd2 || out_data !== 32'hA0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bubble_state: got occ=%0d d=%h rdy=%b, required 2 000000a0 1", occupancy, out_data, in_ready);
    end
    chk_rs1 = 5'd5; chk_rs2 = 5'd0; #1;
    n_tests++;
    if (hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL hazard_hit: got %b, required 1", hazard);
    end
    chk_rs1 = 5'd0; chk_rs2 = 5'd0; #1;
    n_tests++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_x0: got %b, required 0", hazard);
    end
    chk_rs2 = 5'd5; #1;
    n_tests++;
    if (hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL hazard_rs2: got %b, required 1", hazard);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hB0) begin
      n_fail++;
      $display("FAIL bubble_collapse: got v=%b d=%h, required 1 000000b0", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_rs1 = 5'd5; chk_rs2 = 5'd5; #1;
    n_tests++;
    if (hazard !== 1'b0 || occupancy !== 5'd0) begin
      n_fail++;
      $display("FAIL hazard_clear: got hz=%b occ=%0d, required 0 0", hazard, occupancy);
    end
    chk_rs1 = '0; chk_rs2 = '0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, DATA_W'(32'h30 + k), 5'd6, 1'b1);
      tick();
    end
    chk_rs1 = 5'd6; #1;
    n_tests++;
    if (hazard !== 1'b1 || occupancy !== 5'd4) begin
      n_fail++;
      $display("FAIL flush_pre: got hz=%b occ=%0d, required 1 4", hazard, occupancy);
    end
    drive(1'b1, 32'h99, 5'd6, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    n_tests++;
    if (occupancy !== 5'd0 || out_valid !== 1'b0 || hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: got occ=%0d v=%b hz=%b, required 0 0 0", occupancy, out_valid, hazard);
    end
    for (int k = 0; k < 5; k++) tick();
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_ghost: got v=%b occ=%0d, required 0 0", out_valid, occupancy);
    end
    chk_rs1 = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, DATA_W'(32'h40 + k), 5'd3, 1'b1);
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got v=%b, required 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 5'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_now: got v=%b occ=%0d rdy=%b, required 0 0 1", out_valid, occupancy, in_ready);
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (occupancy !== 5'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_after: got occ=%0d v=%b, required 0 0", occupancy, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom, ADDR_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      out_ready = (c < 20) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      n_tests++;
      if (occupancy !== CNT_W'(sb_q.size()) || occupancy > 5'd4) begin
        n_fail++;
        $display("FAIL b2b_occ c%0d: got %0d, required %0d", c, occupancy, sb_q.size());
      end
    end
    drain();
  endtask

`ifdef PHILV_PIPE_FWD_EN
  task automatic test_fwd();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd7, 1'b1);
    tick();
    drive(1'b1, 32'hB, 5'd7, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    chk_rs1 = 5'd7; chk_rs2 = 5'd3; #1;
    n_tests++;
    if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hB || fwd2_hit !== 1'b0 || fwd2_data !== '0 || hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd: got h1=%b d1=%h h2=%b d2=%h hz=%b, required 1 0000000b 0 00000000 1",
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, hazard);
    end
    chk_rs1 = '0; chk_rs2 = '0;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_bubble_hazard();
    test_flush();
    test_async_reset();
    test_back_to_back();
`ifdef PHILV_PIPE_FWD_EN
    test_fwd();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
